display_scheduler: RTL
======================

Name: display_scheduler

Overview:
- Sequences all traffic to the MAX7219 7-segment driver on behalf of the stopwatch.
- After reset it issues the chip configuration words, then refreshes the six digits in one burst per refresh tick.
- It snapshots the counter-chain outputs so that every frame is coherent, and honours the display enable used for lap-time freeze.
- Words are handed one at a time to a downstream SPI word shifter over a valid/ready handshake.

Parameters:
- INTENSITY, 4'h8, value written to the MAX7219 intensity register (0x0A).
- SCAN_LIMIT, 3'd5, value written to the scan-limit register (0x0B); 5 selects digits 0-5.
- DECODE_MASK, 8'h3F, value written to the decode-mode register (0x09); selects code-B decoding on digits 0-5.

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous reset, active-high.
- ena  in  1  display enable; low freezes the shown value (lap time).
- refresh_tick  in  1  single-cycle pulse requesting one display refresh.
- min_X0  in  3  tens of minutes.
- min_0X  in  4  units of minutes.
- sec_X0  in  3  tens of seconds.
- sec_0X  in  4  units of seconds.
- ces_X0  in  4  tenths of a second.
- ces_0X  in  4  hundredths of a second.
- word_data  out  16  SPI word {4'h0, addr[3:0], data[7:0]}.
- word_valid  out  1  word_data is valid.
- word_ready  in  1  shifter accepts the word on this edge.
- init_done  out  1  configuration sequence has completed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (res high at a clk edge):
  - Values after the edge: word_valid=0, word_data=0, init_done=0, busy=1, pending=0, state=INIT, word index=0.
  - A reset that arrives mid-word or mid-frame aborts the transfer, and the configuration sequence restarts from word 0.
- Handshake:
  - A word transfers on an edge where word_valid and word_ready are both high.
  - word_data must stay stable while word_valid=1 and word_ready=0.
  - After a transfer, the next word of the same sequence is presented in the following cycle; word_valid may stay high across back-to-back words.
  - word_ready while word_valid=0 is ignored.
- INIT state: issues 5 words in this order: 0x0C01, 0x09 & DECODE_MASK, 0x0A & {4'h0,INTENSITY}, 0x0B & {5'h0,SCAN_LIMIT}, 0x0F00.
  - When the 5th word transfers: init_done=1 from the next cycle, and the state goes to IDLE.
- IDLE state: busy=0, word_valid=0.
  - If pending=1 or refresh_tick=1, and ena=1: go to SNAP and clear pending.
  - If ena=0: ticks are ignored and pending is cleared.
- SNAP state (1 cycle): registers all six digit inputs into the snapshot, then goes to SEND.
- SEND state: issues 6 words from the snapshot, in this order:
  - 0x01 & ces_0X
  - 0x02 & ces_X0
  - 0x03 & (0x80|sec_0X), with the decimal point set
  - 0x04 & sec_X0
  - 0x05 & (0x80|min_0X), with the decimal point set
  - 0x06 & min_X0
  - 3-bit inputs are zero-extended.
  - Any nibble >9 is replaced by 0xF (code-B blank); the DP bit is kept.
  - After the 6th transfer, go to IDLE.
- Latency: with word_ready tied high, the first digit word is valid 2 cycles after a tick sampled in IDLE, and the frame takes 6 consecutive cycles.
- Tick while busy (INIT, SNAP or SEND):
  - Sets pending; at most one request is queued and further ticks are merged.
  - The queued frame starts from IDLE on the cycle after the current sequence ends, provided ena=1.
- ena falling during SEND: the current frame completes unchanged (no partial frame), then the block idles.
- Input changes during SEND never affect words of the frame in flight.
- init_done stays 1 until the next reset.

Test Plan:
- Reset, then word_ready=1 -> exactly 0x0C01, 0x093F, 0x0A08, 0x0B05, 0x0F00 on 5 consecutive transfers; init_done rises the cycle after the last; busy falls.
- After init, digits 59:47:83 (min_X0=5, min_0X=9, sec_X0=4, sec_0X=7, ces_X0=8, ces_0X=3), one tick -> 0x0103, 0x0208, 0x0387, 0x0404, 0x0589, 0x0605.
- word_ready toggled 1-0-0-1 randomly during a frame -> word_data stable while stalled, no word lost or duplicated, 6 transfers total.
- Three ticks during one frame, digits changed mid-frame -> current frame uses the old snapshot; exactly one extra frame follows, carrying the new values.
- ena=0 with ticks applied -> no word_valid; ena dropped mid-frame -> the frame completes, then no further frames.
- res asserted during the 3rd config word -> word_valid=0 next cycle; the sequence restarts at 0x0C01. ces_0X=4'hC -> data nibble 0xF.

Source files
------------

// File: rtl/display_scheduler.sv
// =============================================================================
// display_scheduler: sequences MAX7219 config words and coherent 6-digit
// refresh frames to a downstream SPI word shifter (valid/ready).
// Revision: 1.0
// =============================================================================
`default_nettype none

module display_scheduler #(
  parameter logic [3:0] INTENSITY   = 4'h8,
  parameter logic [2:0] SCAN_LIMIT  = 3'd5,
  parameter logic [7:0] DECODE_MASK = 8'h3F
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic        refresh_tick,
  input  logic [2:0]  min_X0,
  input  logic [3:0]  min_0X,
  input  logic [2:0]  sec_X0,
  input  logic [3:0]  sec_0X,
  input  logic [3:0]  ces_X0,
  input  logic [3:0]  ces_0X,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        init_done,
  output logic        busy
);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_SNAP = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  localparam logic [2:0] LAST_CFG   = 3'd4;
  localparam logic [2:0] LAST_DIGIT = 3'd5;

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic        init_done_q, init_done_d;
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;
  logic [23:0] snap_q, snap_d;

  logic [23:0] live_digits;
  logic        xfer;

  function automatic logic [15:0] cfg_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h0C01;
      3'd1:    w = {8'h09, DECODE_MASK};
      3'd2:    w = {8'h0A, 4'h0, INTENSITY};
      3'd3:    w = {8'h0B, 5'h00, SCAN_LIMIT};
      default: w = 16'h0F00;
    endcase
    return w;
  endfunction

  // Code-B blank for anything that is not a decimal digit.
  function automatic logic [3:0] blank(input logic [3:0] n);
    return (n > 4'd9) ? 4'hF : n;
  endfunction

  // Digit register idx+1; the decimal point separates min.sec.ces.
  function automatic logic [15:0] digit_word(input logic [2:0] idx, input logic [23:0] d);
    logic [3:0] nib;
    logic       dp;
    case (idx)
      3'd0:    nib = d[3:0];
      3'd1:    nib = d[7:4];
      3'd2:    nib = d[11:8];
      3'd3:    nib = d[15:12];
      3'd4:    nib = d[19:16];
      default: nib = d[23:20];
    endcase
    dp = (idx == 3'd2) || (idx == 3'd4);
    return {4'h0, ({1'b0, idx} + 4'd1), dp, 3'b000, blank(nib)};
  endfunction

  assign live_digits = {1'b0, min_X0, min_0X, 1'b0, sec_X0, sec_0X, ces_X0, ces_0X};
  assign xfer        = valid_q && word_ready;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: if (xfer && idx_q == LAST_CFG) state_d = S_IDLE;
      S_IDLE: if (ena && (pending_q || refresh_tick)) state_d = S_SNAP;
      S_SNAP: state_d = S_SEND;
      S_SEND: if (xfer && idx_q == LAST_DIGIT) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    idx_d       = idx_q;
    pending_d   = pending_q | refresh_tick;
    init_done_d = init_done_q;
    valid_d     = valid_q;
    data_d      = data_q;
    snap_d      = snap_q;
    case (state_q)
      S_INIT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = cfg_word(idx_q);
        end else if (xfer) begin
          if (idx_q == LAST_CFG) begin
            valid_d     = 1'b0;
            idx_d       = 3'd0;
            init_done_d = 1'b1;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = cfg_word(idx_q + 3'd1);
          end
        end
      end
      S_IDLE: begin
        // A request is either consumed here or dropped because ena is low.
        pending_d = 1'b0;
        valid_d   = 1'b0;
      end
      S_SNAP: begin
        // The first word comes from the live inputs, which are being
        // snapshotted on this same edge, so the frame stays coherent.
        snap_d  = live_digits;
        idx_d   = 3'd0;
        valid_d = 1'b1;
        data_d  = digit_word(3'd0, live_digits);
      end
      default: begin
        if (xfer) begin
          if (idx_q == LAST_DIGIT) begin
            valid_d = 1'b0;
            idx_d   = 3'd0;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = digit_word(idx_q + 3'd1, snap_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      idx_q       <= 3'd0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= 16'h0000;
      snap_q      <= 24'h000000;
    end else begin
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      snap_q      <= snap_d;
    end
  end

  assign word_data  = data_q;
  assign word_valid = valid_q;
  assign init_done  = init_done_q;

endmodule

`default_nettype wire
